stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised, registered N-way 32-bit-class multiplexer for the RISC-V datapath. It generalises the combinational 2:1 select used on the operand and writeback paths. It selects one of N valid/ready input channels, either by an explicit select or by round-robin arbitration. The selection lands in a single-entry output register with a valid/ready handshake, so it can sit between pipeline stages, for example where the writeback, load and CSR results merge.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- N, 4, number of input channels (2..16)
- MODE, 0, 0 = explicit select via `sel`, 1 = round-robin arbitration (`sel` ignored)
- SW, $clog2(N), select/channel-index width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i has data
- in_ready  out  N  channel i transfer accepted this cycle
- sel  in  SW  channel to pass (MODE 0 only)
- out_data  out  WIDTH  registered selected data
- out_chan  out  SW  index of the channel that supplied out_data
- out_valid  out  1  output register holds data
- out_ready  in  1  downstream accepts out_data

## Operation
- One clock domain. Reset is asynchronous and active-low. All state is cleared on the falling edge of rst_n.
- Reset values:
  - out_valid=0, out_data=0, out_chan=0
  - Round-robin pointer ptr=0 (channel 0 has highest priority first)
  - in_ready=0 for all channels
- load = !out_valid || out_ready. The slot is free, or it is draining this cycle.
- Grant (combinational, at most one-hot):
  - MODE 0: grant channel `sel` iff sel < N and in_valid[sel]. If sel >= N, nothing is granted.
  - MODE 1: first i with in_valid[i], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
- in_ready[i] = load && grant[i]. An input transfer happens when in_valid[i] && in_ready[i].
- On an input transfer:
  - out_data ← channel data, out_chan ← i, out_valid ← 1.
  - MODE 1 only: ptr ← (i+1) mod N.
- On load with no grant: out_valid ← 1 only if a transfer occurs, otherwise 0. out_data and out_chan hold their previous values (don't-care when invalid).
- ptr is unchanged when no transfer occurs. It is also unchanged in MODE 0.
- Output stability: while out_valid && !out_ready, out_data and out_chan must not change. All in_ready are 0 in that state.
- Inputs may drop in_valid without a transfer; no requirement is placed on the sender.
- Reset mid-operation: held data is discarded and out_valid drops asynchronously. The first grant after reset comes from ptr=0.

## Timing
- Latency: 1 clock from input transfer to out_valid/out_data.
- Throughput: 1 transfer per clock when out_ready is held high.
- Simultaneous drain and fill in the same cycle: the new data replaces the old, out_valid stays 1, and there is no bubble.
- in_ready depends combinationally on in_valid, sel, ptr, out_valid and out_ready.
- No combinational path from in_* or sel to out_data, out_chan or out_valid.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel receives exactly one grant in every N consecutive transfers.

## Test plan
All scenarios use WIDTH=32, N=4.
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0 immediately, with no clock edge needed. After release with all inputs valid in MODE 1, the first out_chan is 0.
- MODE 0 basic: in_data ch0=0x0, ch1=0x1, ch2=0xA5A5_0002, ch3=0xFFFF_FFFF, all valid, sel=2, out_ready=1 → in_ready=4'b0100. Next cycle out_data=0xA5A5_0002, out_chan=2. Then sel=1 gives out_data=0x1 one cycle later.
- MODE 0 gating: sel=3, in_valid[3]=0, in_valid[0]=1 → in_ready=0. out_valid falls to 0 after the current word drains.
- Backpressure: out_valid=1 with out_data=0x1234_5678 and out_ready=0 held for 5 cycles while inputs change → out_data and out_chan stay constant and in_ready=0. Raising out_ready gives the next word one cycle later with no bubble.
- MODE 1 fairness: all in_valid=1, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3.
- MODE 1 skip: only ch1 and ch3 valid, ptr=2 → grant order 3,1,3,1. Channels 0 and 2 never have in_ready=1.

Source files
------------

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-way valid/ready stream mux with explicit-select or round-robin grant
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SW-1:0] ptr;
  logic          load;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic [SW-1:0] scan_idx;

  // Slot can take new data when empty or when its current word drains this cycle.
  assign load = !out_valid || out_ready;

  // Grant selection: explicit select, or first valid channel scanning upward from ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (MODE == 0) begin
      if ((32'(sel) < N) && in_valid[sel]) begin
        grant_idx = sel;
        grant_any = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_idx = SW'((int'(ptr) + k) % N);
        if (!grant_any && in_valid[scan_idx]) begin
          grant_idx = scan_idx;
          grant_any = 1'b1;
        end
      end
    end
    grant[grant_idx] = grant_any;
  end

  // Ready only reaches the granted channel, and never while reset is asserted.
  assign in_ready = {N{rst_n & load}} & grant;

  // Single-entry output register plus round-robin pointer update on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_data <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_chan <= grant_idx;
        if (MODE == 1) begin
          ptr <= SW'((int'(grant_idx) + 1) % N);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized self-checking bench for stream_mux_rr in both select modes
module tb_stream_mux_rr;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [1:0]   sel = '0;
  logic         out_ready = 1'b0;

  logic [3:0]   r0, r1;
  logic [31:0]  d0, d1;
  logic [1:0]   c0, c1;
  logic         v0, v1;

  int checks = 0;
  int failures = 0;

  // Reference model state, one set per mode.
  logic        mv0, mv1;
  logic [31:0] md0, md1;
  int          mc0, mc1, mp1;
  int          g0, g1;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(r0),
    .sel(sel), .out_data(d0), .out_chan(c0), .out_valid(v0), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(r1),
    .sel(sel), .out_data(d1), .out_chan(c1), .out_valid(v1), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Which channel the rules pick right now, or -1 when nothing is eligible.
  function automatic int mgrant(int mode, int ptr);
    if (mode == 0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int mode);
    int g;
    logic full;
    g = mgrant(mode, mp1);
    full = (mode == 0) ? mv0 : mv1;
    if (!rst_n || (full && !out_ready) || g < 0) return 4'b0;
    return 4'b1 << g;
  endfunction

  // Behavioural model: one word slot per mode, refilled whenever it is free or draining.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv0 <= 1'b0; md0 <= '0; mc0 <= 0;
      mv1 <= 1'b0; md1 <= '0; mc1 <= 0; mp1 <= 0;
    end else begin
      g0 = mgrant(0, mp1);
      g1 = mgrant(1, mp1);
      if (!mv0 || out_ready) begin
        mv0 <= (g0 >= 0);
        if (g0 >= 0) begin md0 <= in_data[g0*32 +: 32]; mc0 <= g0; end
      end
      if (!mv1 || out_ready) begin
        mv1 <= (g1 >= 0);
        if (g1 >= 0) begin md1 <= in_data[g1*32 +: 32]; mc1 <= g1; mp1 <= (g1 + 1) % N; end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 4'b1111; out_ready = 1'b1; sel = 2'd1;
    #1;
    checks++;
    if ({v0, v1, d0, d1, c0, c1} !== '0 || r0 !== 4'b0 || r1 !== 4'b0) begin
      failures++; $display("FAIL reset_initial got v=%b%b d0=%h d1=%h r=%b/%b want zeros", v0, v1, d0, d1, r0, r1);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) in_data[j*32 +: 32] = $urandom;
    end
    #2;
    checks++;
    if (v0 !== 1'b1 || v1 !== 1'b1) begin
      failures++; $display("FAIL reset_prefill got v=%b%b want 11", v0, v1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v0, v1, d0, d1, c0, c1} !== '0 || r0 !== 4'b0 || r1 !== 4'b0) begin
      failures++; $display("FAIL reset_async got v=%b%b d0=%h d1=%h c=%0d/%0d r=%b/%b want zeros",
                           v0, v1, d0, d1, c0, c1, r0, r1);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (v1 !== 1'b1 || c1 !== 2'd0 || d1 !== in_data[31:0]) begin
      failures++; $display("FAIL reset_first_grant got v=%b chan=%0d data=%h want 1 0 %h", v1, c1, d1, in_data[31:0]);
    end
  endtask

  task automatic test_mode0_basic();
    logic [31:0] exp_d [2];
    logic [1:0]  sels [2];
    exp_d[0] = 32'hA5A5_0002; exp_d[1] = 32'h0000_0001;
    sels[0] = 2'd2; sels[1] = 2'd1;
    in_data = {32'hFFFF_FFFF, 32'hA5A5_0002, 32'h0000_0001, 32'h0000_0000};
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); sel = sels[i]; #1;
      checks++;
      if (r0 !== (4'b1 << sels[i])) begin
        failures++; $display("FAIL m0_basic_ready[%0d] got %b want %b", i, r0, 4'b1 << sels[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (v0 !== 1'b1 || d0 !== exp_d[i] || c0 !== sels[i]) begin
        failures++; $display("FAIL m0_basic_out[%0d] got v=%b d=%h c=%0d want 1 %h %0d", i, v0, d0, c0, exp_d[i], sels[i]);
      end
    end
  endtask

  task automatic test_mode0_gating();
    @(negedge clk); sel = 2'd3; in_valid = 4'b0001; out_ready = 1'b1; #1;
    checks++;
    if (r0 !== 4'b0) begin
      failures++; $display("FAIL m0_gating_ready got %b want 0000", r0);
    end
    @(posedge clk); #1;
    checks++;
    if (v0 !== 1'b0) begin
      failures++; $display("FAIL m0_gating_drain got v=%b want 0", v0);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    sel = 2'd0; in_data[31:0] = 32'h1234_5678; in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N; j++) in_data[j*32 +: 32] = $urandom;
      in_valid = 4'($urandom); sel = 2'($urandom);
      #1;
      checks++;
      if (r0 !== 4'b0 || r1 !== 4'b0 || v0 !== 1'b1 || d0 !== 32'h1234_5678 || c0 !== 2'd0) begin
        failures++; $display("FAIL backpressure_hold[%0d] got r=%b/%b v=%b d=%h c=%0d want 0/0 1 12345678 0",
                             i, r0, r1, v0, d0, c0);
      end
      checks++;
      if (v1 !== mv1 || d1 !== md1 || int'(c1) !== mc1) begin
        failures++; $display("FAIL backpressure_rr_hold[%0d] got v=%b d=%h c=%0d want %b %h %0d", i, v1, d1, c1, mv1, md1, mc1);
      end
      @(negedge clk);
    end
    sel = 2'd2; in_valid = 4'b1111; in_data[95:64] = 32'hCAFE_0002; out_ready = 1'b1; #1;
    checks++;
    if (r0 !== 4'b0100) begin
      failures++; $display("FAIL backpressure_release_ready got %b want 0100", r0);
    end
    @(posedge clk); #1;
    checks++;
    if (v0 !== 1'b1 || d0 !== 32'hCAFE_0002 || c0 !== 2'd2) begin
      failures++; $display("FAIL backpressure_release_out got v=%b d=%h c=%0d want 1 cafe0002 2", v0, d0, c0);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    @(negedge clk); in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (r1 !== (4'b1 << (i % N))) begin
        failures++; $display("FAIL fairness_ready[%0d] got %b want %b", i, r1, 4'b1 << (i % N));
      end
      @(posedge clk); #1;
      checks++;
      if (v1 !== 1'b1 || int'(c1) !== i % N) begin
        failures++; $display("FAIL fairness_chan[%0d] got v=%b c=%0d want 1 %0d", i, v1, c1, i % N);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skip();
    int order [4];
    order[0] = 3; order[1] = 1; order[2] = 3; order[3] = 1;
    apply_reset();
    @(negedge clk); in_valid = 4'b0010; out_ready = 1'b1;
    @(negedge clk); in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (r1[0] !== 1'b0 || r1[2] !== 1'b0 || r1 !== (4'b1 << order[i])) begin
        failures++; $display("FAIL skip_ready[%0d] got %b want %b", i, r1, 4'b1 << order[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (int'(c1) !== order[i]) begin
        failures++; $display("FAIL skip_chan[%0d] got %0d want %0d", i, c1, order[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) in_data[j*32 +: 32] = $urandom;
      in_valid = 4'($urandom);
      sel = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (r0 !== exp_ready(0) || r1 !== exp_ready(1)) begin
        failures++; $display("FAIL random_ready[%0d] got %b/%b want %b/%b", i, r0, r1, exp_ready(0), exp_ready(1));
      end
      @(posedge clk); #1;
      checks++;
      if (v0 !== mv0 || (mv0 && (d0 !== md0 || int'(c0) !== mc0))) begin
        failures++; $display("FAIL random_m0_out[%0d] got v=%b d=%h c=%0d want %b %h %0d", i, v0, d0, c0, mv0, md0, mc0);
      end
      checks++;
      if (v1 !== mv1 || (mv1 && (d1 !== md1 || int'(c1) !== mc1))) begin
        failures++; $display("FAIL random_m1_out[%0d] got v=%b d=%h c=%0d want %b %h %0d", i, v1, d1, c1, mv1, md1, mc1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_mode0_gating();
    test_backpressure();
    test_fairness();
    test_skip();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
